// File: rtl/seq_detect_prog.sv
// Programmable serial sequence detector: runtime pattern (1..MAX_LEN bits),
// overlap mode and input qualifier; registered match pulse plus a
// saturating match counter.
module seq_detect_prog #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  input  logic               in_valid,
  input  logic               x,
  input  logic               clr_cnt,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               armed,
  output logic               cfg_err
);

  typedef enum logic [1:0] {UNCFG, FILL, ARMED} state_t;

  state_t             state, state_n;
  logic [MAX_LEN-1:0] hist, hist_n, cfg_pat, mask;
  logic [LEN_W-1:0]   fill, fill_n, cfg_len;
  logic               cfg_ovl;
  logic               cfg_legal;
  logic               sample;
  logic               hit;
  logic               restart;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= UNCFG;
    else     state <= state_n;
  end

  // Datapath look-ahead and hit detection (cfg_load steals the sample slot)
  always_comb begin
    cfg_legal = (pat_len != '0) && (pat_len <= LEN_W'(MAX_LEN));
    sample    = in_valid && !cfg_load && (state != UNCFG);
    hist_n    = {hist[MAX_LEN-2:0], x};
    fill_n    = (fill >= LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : fill + LEN_W'(1);
    mask      = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < cfg_len);
    end
    hit       = sample && (fill_n >= cfg_len) && ((hist_n & mask) == (cfg_pat & mask));
    restart   = hit && !cfg_ovl;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    if (cfg_load) begin
      state_n = cfg_legal ? FILL : UNCFG;
    end else if (sample) begin
      if (restart)                 state_n = FILL;
      else if (fill_n >= cfg_len)  state_n = ARMED;
      else                         state_n = FILL;
    end
  end

  // Config latch and shift history; an illegal load wipes the old config
  always_ff @(posedge clk) begin
    if (rst) begin
      hist    <= '0;
      fill    <= '0;
      cfg_pat <= '0;
      cfg_len <= '0;
      cfg_ovl <= 1'b0;
    end else if (cfg_load) begin
      hist    <= '0;
      fill    <= '0;
      cfg_pat <= cfg_legal ? pattern : '0;
      cfg_len <= cfg_legal ? pat_len : '0;
      cfg_ovl <= cfg_legal ? overlap : 1'b0;
    end else if (sample) begin
      hist    <= restart ? '0 : hist_n;
      fill    <= restart ? '0 : fill_n;
    end
  end

  // Registered outputs: match pulse, saturating counter, status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      match     <= 1'b0;
      match_cnt <= '0;
      armed     <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      match <= hit;
      armed <= (state_n != UNCFG);
      if (cfg_load) cfg_err <= !cfg_legal;
      if (clr_cnt)                      match_cnt <= '0;
      else if (hit && (match_cnt != '1)) match_cnt <= match_cnt + CNT_W'(1);
    end
  end

endmodule
